// File: rtl/sar_cmp_search.sv
// Successive-approximation search that drives a magnitude comparator's B operand until it matches A.
// Latency: probes*SETTLE cycles from accepted start to done; start is ignored while a search is running.
module sar_cmp_search #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             a_less_b,
   input  logic             a_equal_b,
   input  logic             a_greater_b,
   output logic [WIDTH-1:0] cmp_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH:0]   probes,
   output logic             err
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, WAIT, FINISH} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] lo, lo_nxt, hi, hi_nxt;
   logic [WIDTH-1:0] cmp_b_nxt, result_nxt;
   logic [WIDTH:0]   probes_nxt;
   logic             err_nxt;
   logic [CW-1:0]    settle_cnt, settle_cnt_nxt;

   // Sum taken one bit wider so lo+hi cannot overflow at the top of the range.
   function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] h);
      logic [WIDTH:0] sum;
      sum = {1'b0, l} + {1'b0, h};
      return sum[WIDTH:1];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lo         <= '0;
         hi         <= '0;
         cmp_b      <= '0;
         result     <= '0;
         probes     <= '0;
         err        <= 1'b0;
         settle_cnt <= '0;
      end else begin
         state      <= state_nxt;
         lo         <= lo_nxt;
         hi         <= hi_nxt;
         cmp_b      <= cmp_b_nxt;
         result     <= result_nxt;
         probes     <= probes_nxt;
         err        <= err_nxt;
         settle_cnt <= settle_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      lo_nxt         = lo;
      hi_nxt         = hi;
      cmp_b_nxt      = cmp_b;
      result_nxt     = result;
      probes_nxt     = probes;
      err_nxt        = err;
      settle_cnt_nxt = settle_cnt;
      case (state)
         IDLE: begin
            if (start) begin
               lo_nxt         = '0;
               hi_nxt         = '1;
               probes_nxt     = '0;
               err_nxt        = 1'b0;
               cmp_b_nxt      = mid_of('0, '1);
               settle_cnt_nxt = SETTLE_LOAD;
               state_nxt      = WAIT;
            end
         end
         WAIT: begin
            if (settle_cnt != '0) begin
               settle_cnt_nxt = settle_cnt - CW'(1);
            end else begin
               probes_nxt = probes + (WIDTH+1)'(1);
               if (!({a_less_b, a_equal_b, a_greater_b} inside {3'b100, 3'b010, 3'b001})) begin
                  err_nxt    = 1'b1;
                  result_nxt = cmp_b;
                  state_nxt  = FINISH;
               end else if (a_equal_b) begin
                  result_nxt = cmp_b;
                  state_nxt  = FINISH;
               end else if (a_less_b) begin
                  // Nothing left below the probe: the comparator contradicted itself.
                  if (cmp_b == lo) begin
                     err_nxt   = 1'b1;
                     state_nxt = FINISH;
                  end else begin
                     hi_nxt         = cmp_b - WIDTH'(1);
                     cmp_b_nxt      = mid_of(lo, cmp_b - WIDTH'(1));
                     settle_cnt_nxt = SETTLE_LOAD;
                  end
               end else begin
                  if (cmp_b == hi) begin
                     err_nxt   = 1'b1;
                     state_nxt = FINISH;
                  end else begin
                     lo_nxt         = cmp_b + WIDTH'(1);
                     cmp_b_nxt      = mid_of(cmp_b + WIDTH'(1), hi);
                     settle_cnt_nxt = SETTLE_LOAD;
                  end
               end
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == WAIT);
   assign done = (state == FINISH);

endmodule

// File: tb/tb_sar_cmp_search.sv
// Directed bench for sar_cmp_search: a WIDTH=4/SETTLE=1 and a WIDTH=2/SETTLE=3 instance,
// each facing a behavioural comparator; expected outcomes are queued at start and popped at done.
module tb_sar_cmp_search;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start4 = 1'b0, start2 = 1'b0;
   logic [3:0] a4 = '0;
   logic [1:0] a2 = '0;
   logic       flip = 1'b0;
   logic       sel2 = 1'b0;

   logic       lt4, eq4, gt4, lt2, eq2, gt2;
   logic [3:0] cmp_b4, result4;
   logic [4:0] probes4;
   logic       busy4, done4, err4;
   logic [1:0] cmp_b2, result2;
   logic [2:0] probes2;
   logic       busy2, done2, err2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] res;
      logic [4:0] prb;
      logic       err;
   } exp_t;

   exp_t       sb_q[$];
   logic [3:0] tr_q[$];

   always #5 clk = ~clk;

   // Comparator models; flip forces an impossible less+greater answer.
   assign lt4 = flip ? 1'b1 : (a4 < cmp_b4);
   assign gt4 = flip ? 1'b1 : (a4 > cmp_b4);
   assign eq4 = flip ? 1'b0 : (a4 == cmp_b4);
   assign lt2 = (a2 < cmp_b2);
   assign gt2 = (a2 > cmp_b2);
   assign eq2 = (a2 == cmp_b2);

   sar_cmp_search #(.WIDTH(4), .SETTLE(1)) dut4 (
      .clk(clk), .rst(rst), .start(start4),
      .a_less_b(lt4), .a_equal_b(eq4), .a_greater_b(gt4),
      .cmp_b(cmp_b4), .busy(busy4), .done(done4),
      .result(result4), .probes(probes4), .err(err4)
   );

   sar_cmp_search #(.WIDTH(2), .SETTLE(3)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .a_less_b(lt2), .a_equal_b(eq2), .a_greater_b(gt2),
      .cmp_b(cmp_b2), .busy(busy2), .done(done2),
      .result(result2), .probes(probes2), .err(err2)
   );

   logic [3:0] s_cmp, s_res;
   logic [4:0] s_prb;
   logic       s_busy, s_done, s_err;
   assign s_cmp  = sel2 ? {2'b00, cmp_b2}  : cmp_b4;
   assign s_res  = sel2 ? {2'b00, result2} : result4;
   assign s_prb  = sel2 ? {2'b00, probes2} : probes4;
   assign s_busy = sel2 ? busy2 : busy4;
   assign s_done = sel2 ? done2 : done4;
   assign s_err  = sel2 ? err2  : err4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel2) start2 = v;
      else      start4 = v;
   endtask

   // tr holds the expected probe values as nibbles, first probe in the most significant used nibble.
   task automatic search(input bit w2, input int a, input logic [31:0] tr, input int n,
                         input int res, input int prb, input bit e, input bit poke);
      exp_t x;
      int   settle;
      int   ntr;
      int   extra;
      bit   dn;
      bit   first;
      sel2   = w2;
      settle = w2 ? 3 : 1;
      x.res  = 5'(res);
      x.prb  = 5'(prb);
      x.err  = e;
      sb_q.push_back(x);
      for (int i = 0; i < n; i++)
         for (int k = 0; k < settle; k++)
            tr_q.push_back(tr[4*(n-1-i) +: 4]);
      if (w2) a2 = 2'(a);
      else    a4 = 4'(a);
      @(posedge clk); #1 set_start(1'b1);
      @(posedge clk); #1 set_start(1'b0);
      dn = 0; first = 1; ntr = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         if (poke && cyc == 1) set_start(1'b1);
         if (poke && cyc == 2) set_start(1'b0);
         if (s_done) begin
            dn = 1;
            break;
         end
         if (s_busy) begin
            if (first) begin
               chk("err_clear_on_start", 32'(s_err), 0);
               first = 0;
            end
            ntr++;
            if (tr_q.size() != 0) chk("cmp_b_probe", 32'(s_cmp), 32'(tr_q.pop_front()));
         end
      end
      chk("done_seen", 32'(dn), 1);
      chk("busy_cycles", ntr, n * settle);
      chk("busy_low_at_done", 32'(s_busy), 0);
      x = sb_q.pop_front();
      chk("result", 32'(s_res), 32'(x.res));
      chk("probes", 32'(s_prb), 32'(x.prb));
      chk("err", 32'(s_err), 32'(x.err));
      tr_q.delete();
      extra = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (s_done) extra++;
      end
      chk("single_done", extra, 0);
   endtask

   initial begin
      int ndone;
      bit reached;
      #12;
      chk("rst_cmp_b4", 32'(cmp_b4), 0);
      chk("rst_busy4", 32'(busy4), 0);
      chk("rst_done4", 32'(done4), 0);
      chk("rst_result4", 32'(result4), 0);
      chk("rst_probes4", 32'(probes4), 0);
      chk("rst_err4", 32'(err4), 0);
      chk("rst_cmp_b2", 32'(cmp_b2), 0);
      chk("rst_probes2", 32'(probes2), 0);
      @(negedge clk); rst = 1'b0;

      search(0, 0,  32'h7310,  4, 0,  4, 0, 0);
      search(0, 15, 32'h7bdef, 5, 15, 5, 0, 0);

      search(1, 0, 32'h10,  2, 0, 2, 0, 0);
      search(1, 1, 32'h1,   1, 1, 1, 0, 0);
      search(1, 2, 32'h12,  2, 2, 2, 0, 0);
      search(1, 3, 32'h123, 3, 3, 3, 0, 0);

      flip = 1'b1;
      search(0, 3, 32'h7, 1, 7, 1, 1, 0);
      flip = 1'b0;

      search(0, 5, 32'h735, 3, 5, 3, 0, 1);

      // Asynchronous reset part-way through a search for 9.
      sel2 = 1'b0;
      a4   = 4'd9;
      @(posedge clk); #1 start4 = 1'b1;
      @(posedge clk); #1 start4 = 1'b0;
      reached = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         @(negedge clk);
         if (busy4 && cmp_b4 == 4'd9) begin
            reached = 1;
            break;
         end
      end
      chk("reached_third_probe", 32'(reached), 1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_cmp_b", 32'(cmp_b4), 0);
      chk("midrst_busy", 32'(busy4), 0);
      chk("midrst_done", 32'(done4), 0);
      chk("midrst_result", 32'(result4), 0);
      chk("midrst_probes", 32'(probes4), 0);
      chk("midrst_err", 32'(err4), 0);
      ndone = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done4) ndone++;
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done4 || busy4) ndone++;
      end
      chk("no_done_after_rst", ndone, 0);
      search(0, 9, 32'h7b9, 3, 9, 3, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
